stage_sequencer: RTL

//  Generates the 2-bit stage code (LOAD/FETCH/DECODE/EXECUTE) that drives the control unit.

---
 rtl/stage_sequencer_pkg.sv | 17 +
 rtl/stage_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared stage encodings and parameter defaults for the stage sequencer and the
// control unit that decodes its stage code.
package stage_sequencer_pkg;

    // Stage codes are decoded directly by the control unit; keep these values fixed.
    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DECODE  = 2'b10,
        ST_EXECUTE = 2'b11
    } stage_e;

    localparam int PM_AW_DEF = 8;
    localparam int IW_DEF    = 12;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/stage_sequencer.sv
// Stage sequencer: program-load phase over valid/ready, then free-running
// FETCH/DECODE/EXECUTE. Optional single-step control via STAGE_SEQ_STEP_EN.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int PM_AW = PM_AW_DEF,
    parameter int IW    = IW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic             load_valid,
    input  logic [IW-1:0]    load_data,
    input  logic             load_last,
`ifdef STAGE_SEQ_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic             load_ready,
    output logic             pm_wr,
    output logic [PM_AW-1:0] pm_waddr,
    output logic [IW-1:0]    pm_wdata,
    output logic [1:0]       stage,
    output logic [CNT_W-1:0] instr_cnt
);

    stage_e           state_q, state_d;
    logic [PM_AW-1:0] waddr_q, waddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs;
    logic             fetch_go;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef STAGE_SEQ_STEP_EN
    // In step mode FETCH waits for a step pulse; steps seen in DECODE/EXECUTE are dropped.
    assign fetch_go = ~step_mode | step;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        cnt_d      = cnt_q;
        load_ready = (state_q == ST_LOAD);
        hs         = load_valid & load_ready;

        unique case (state_q)
            ST_LOAD: begin
                if (hs) begin
                    waddr_d = waddr_q + 1'b1;
                    // Last address written means memory full: wrap and stop accepting.
                    if (load_last || (&waddr_q)) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (fetch_go) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                cnt_d   = sat_inc(cnt_q);
            end
        endcase

        // Reload wins over everything, including a handshake in the same cycle.
        if (reload) begin
            state_d = ST_LOAD;
            waddr_d = '0;
            cnt_d   = '0;
        end
    end

    assign pm_wr     = hs & ~reload;
    assign pm_waddr  = waddr_q;
    assign pm_wdata  = load_data;
    assign stage     = state_q;
    assign instr_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
